// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: requester push bus and common-data-bus broadcast bundle for cdb_arbiter
interface cdb_arbiter_if #(
  parameter int NREQ = 4,
  parameter int WORD_SIZE = 32,
  parameter int UNIT_SIZE = 8
);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*UNIT_SIZE-1:0] req_tag;
  logic [NREQ*WORD_SIZE-1:0] req_data;
  logic cdb_valid;
  logic [UNIT_SIZE-1:0] cdb_tag;
  logic [WORD_SIZE-1:0] cdb_data;
  logic idle;
  logic [31:0] stat_bcast;
  logic [31:0] stat_stall;
  modport master (
    output req_valid, req_tag, req_data,
    input req_ready, cdb_valid, cdb_tag, cdb_data, idle, stat_bcast, stat_stall
  );
  modport slave (
    input req_valid, req_tag, req_data,
    output req_ready, cdb_valid, cdb_tag, cdb_data, idle, stat_bcast, stat_stall
  );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin CDB arbiter over per-requester result FIFOs.
// Define CDB_ARBITER_STATS_EN for saturating broadcast/stall counters.
module cdb_arbiter #(
  parameter int NREQ = 4,
  parameter int DEPTH = 2,
  parameter int WORD_SIZE = 32,
  parameter int UNIT_SIZE = 8
) (
  input logic clk,
  input logic rst_n,
  cdb_arbiter_if.slave bus
);
  localparam int PW = $clog2(NREQ);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [UNIT_SIZE-1:0] HOLD_TAG = UNIT_SIZE'(8'h7F);
  logic [UNIT_SIZE-1:0] tag_mem [NREQ][DEPTH];
  logic [WORD_SIZE-1:0] data_mem [NREQ][DEPTH];
  logic [AW-1:0] wr_ptr [NREQ];
  logic [AW-1:0] rd_ptr [NREQ];
  logic [CW-1:0] count [NREQ];
  logic [NREQ-1:0] nonempty, ready, push, pop;
  logic [PW-1:0] rr_ptr, winner, idx;
  logic grant, bcast, cdb_valid;
  logic [UNIT_SIZE-1:0] head_tag, cdb_tag;
  logic [WORD_SIZE-1:0] head_data, cdb_data;
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      nonempty[i] = count[i] != '0;
      ready[i] = rst_n && count[i] < CW'(DEPTH);
      push[i] = bus.req_valid[i] && ready[i];
      pop[i] = grant && winner == PW'(i);
    end
  end
  // Scan downward so the closest non-empty FIFO at or after rr_ptr wins.
  always_comb begin
    winner = rr_ptr;
    grant = 1'b0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = PW'((int'(rr_ptr) + k) % NREQ);
      if (nonempty[idx]) begin
        winner = idx;
        grant = 1'b1;
      end
    end
  end
  assign head_tag = tag_mem[winner][rd_ptr[winner]];
  assign head_data = data_mem[winner][rd_ptr[winner]];
  assign bcast = grant && head_tag != HOLD_TAG;
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (push[i]) begin
        tag_mem[i][wr_ptr[i]] <= bus.req_tag[i*UNIT_SIZE +: UNIT_SIZE];
        data_mem[i][wr_ptr[i]] <= bus.req_data[i*WORD_SIZE +: WORD_SIZE];
      end
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (!rst_n) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i] <= '0;
      end else begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
        if (pop[i]) rd_ptr[i] <= rd_ptr[i] + AW'(1);
        count[i] <= count[i] + CW'(push[i]) - CW'(pop[i]);
      end
    end
  end
  // Reserved-tag results are consumed silently; tag/data keep the last broadcast.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      cdb_valid <= 1'b0;
      cdb_tag <= '0;
      cdb_data <= '0;
    end else begin
      cdb_valid <= bcast;
      if (bcast) begin
        cdb_tag <= head_tag;
        cdb_data <= head_data;
      end
      if (grant) rr_ptr <= winner == PW'(NREQ - 1) ? '0 : winner + PW'(1);
    end
  end
  assign bus.req_ready = ready;
  assign bus.cdb_valid = cdb_valid;
  assign bus.cdb_tag = cdb_tag;
  assign bus.cdb_data = cdb_data;
  assign bus.idle = !rst_n || (nonempty == '0 && !cdb_valid);
`ifdef CDB_ARBITER_STATS_EN
  logic [31:0] stat_bcast, stat_stall;
  logic stall;
  assign stall = |(nonempty & ~pop);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_bcast <= '0;
      stat_stall <= '0;
    end else begin
      if (cdb_valid && stat_bcast != '1) stat_bcast <= stat_bcast + 32'd1;
      if (stall && stat_stall != '1) stat_stall <= stat_stall + 32'd1;
    end
  end
  assign bus.stat_bcast = stat_bcast;
  assign bus.stat_stall = stat_stall;
`else
  assign bus.stat_bcast = '0;
  assign bus.stat_stall = '0;
`endif
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: table-driven bench for cdb_arbiter plus hand-written fairness and reset sequences
module tb_cdb_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  cdb_arbiter_if #(.NREQ(4), .WORD_SIZE(32), .UNIT_SIZE(8)) bus ();
  cdb_arbiter #(.NREQ(4), .DEPTH(2), .WORD_SIZE(32), .UNIT_SIZE(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic rst;
    logic [3:0] vld;
    logic [7:0] tb;
    logic [31:0] db;
    logic cv;
    logic [7:0] tag;
    logic [31:0] data;
    logic [3:0] rdy;
    logic idle;
    int bc;
    int st;
  } vec_t;
  vec_t v [23];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [3:0] vld, input logic [7:0] tb, input logic [31:0] db);
    bus.req_valid = vld;
    for (int i = 0; i < 4; i++) begin
      bus.req_tag[i*8 +: 8] = tb + 8'(i);
      bus.req_data[i*32 +: 32] = db + 32'(i);
    end
  endtask
  initial begin
    logic seen, stale;
    // requester i gets tag tb+i and data db+i
    v[0]  = '{1'b0, 4'hF, 8'hAA, 32'h0,        1'b0, 8'h00, 32'h0,        4'h0, 1'b1, 0, 0};
    v[1]  = '{1'b1, 4'h0, 8'h00, 32'h0,        1'b0, 8'h00, 32'h0,        4'hF, 1'b1, 0, 0};
    v[2]  = '{1'b1, 4'hF, 8'h10, 32'h100,      1'b0, 8'h00, 32'h0,        4'hF, 1'b0, 0, 0};
    v[3]  = '{1'b1, 4'h0, 8'h00, 32'h0,        1'b1, 8'h10, 32'h100,      4'hF, 1'b0, 0, 1};
    v[4]  = '{1'b1, 4'h0, 8'h00, 32'h0,        1'b1, 8'h11, 32'h101,      4'hF, 1'b0, 1, 2};
    v[5]  = '{1'b1, 4'h0, 8'h00, 32'h0,        1'b1, 8'h12, 32'h102,      4'hF, 1'b0, 2, 3};
    v[6]  = '{1'b1, 4'h0, 8'h00, 32'h0,        1'b1, 8'h13, 32'h103,      4'hF, 1'b0, 3, 3};
    v[7]  = '{1'b1, 4'h0, 8'h00, 32'h0,        1'b0, 8'h13, 32'h103,      4'hF, 1'b1, 4, 3};
    v[8]  = '{1'b1, 4'h4, 8'h1F, 32'h3,        1'b0, 8'h13, 32'h103,      4'hF, 1'b0, 4, 3};
    v[9]  = '{1'b1, 4'h0, 8'h00, 32'h0,        1'b1, 8'h21, 32'h5,        4'hF, 1'b0, 4, 3};
    v[10] = '{1'b1, 4'h0, 8'h00, 32'h0,        1'b0, 8'h21, 32'h5,        4'hF, 1'b1, 5, 3};
    v[11] = '{1'b1, 4'h7, 8'h50, 32'h500,      1'b0, 8'h21, 32'h5,        4'hF, 1'b0, 5, 3};
    v[12] = '{1'b1, 4'h8, 8'h2D, 32'hFFD,      1'b1, 8'h50, 32'h500,      4'hF, 1'b0, 5, 4};
    v[13] = '{1'b1, 4'h8, 8'h2E, 32'h1FFD,     1'b1, 8'h51, 32'h501,      4'h7, 1'b0, 6, 5};
    v[14] = '{1'b1, 4'h8, 8'h2F, 32'h2FFD,     1'b1, 8'h52, 32'h502,      4'h7, 1'b0, 7, 6};
    v[15] = '{1'b1, 4'h8, 8'h2F, 32'h2FFD,     1'b1, 8'h30, 32'h1000,     4'hF, 1'b0, 8, 6};
    v[16] = '{1'b1, 4'h8, 8'h2F, 32'h2FFD,     1'b1, 8'h31, 32'h2000,     4'hF, 1'b0, 9, 6};
    v[17] = '{1'b1, 4'h0, 8'h00, 32'h0,        1'b1, 8'h32, 32'h3000,     4'hF, 1'b0, 10, 6};
    v[18] = '{1'b1, 4'h0, 8'h00, 32'h0,        1'b0, 8'h32, 32'h3000,     4'hF, 1'b1, 11, 6};
    v[19] = '{1'b1, 4'h1, 8'h7F, 32'h0,        1'b0, 8'h32, 32'h3000,     4'hF, 1'b0, 11, 6};
    v[20] = '{1'b1, 4'h1, 8'h40, 32'hFFFFFFF9, 1'b0, 8'h32, 32'h3000,     4'hF, 1'b0, 11, 6};
    v[21] = '{1'b1, 4'h0, 8'h00, 32'h0,        1'b1, 8'h40, 32'hFFFFFFF9, 4'hF, 1'b0, 11, 6};
    v[22] = '{1'b1, 4'h0, 8'h00, 32'h0,        1'b0, 8'h40, 32'hFFFFFFF9, 4'hF, 1'b1, 12, 6};
    for (int r = 0; r < 23; r++) begin
      rst_n = v[r].rst;
      drive(v[r].vld, v[r].tb, v[r].db);
      step();
      chk($sformatf("row%0d cdb_valid", r), 64'(bus.cdb_valid), 64'(v[r].cv));
      chk($sformatf("row%0d cdb_tag", r), 64'(bus.cdb_tag), 64'(v[r].tag));
      chk($sformatf("row%0d cdb_data", r), 64'(bus.cdb_data), 64'(v[r].data));
      chk($sformatf("row%0d req_ready", r), 64'(bus.req_ready), 64'(v[r].rdy));
      chk($sformatf("row%0d idle", r), 64'(bus.idle), 64'(v[r].idle));
`ifdef CDB_ARBITER_STATS_EN
      chk($sformatf("row%0d stat_bcast", r), 64'(bus.stat_bcast), 64'(v[r].bc));
      chk($sformatf("row%0d stat_stall", r), 64'(bus.stat_stall), 64'(v[r].st));
`endif
    end
    // requester 0 stays backlogged; requester 1's single result must still get through
    drive(4'h1, 8'h60, 32'h600);
    for (int c = 0; c < 3; c++) step();
    chk("fair ready1", 64'(bus.req_ready[1]), 64'd1);
    bus.req_valid = 4'h3;
    bus.req_tag[15:8] = 8'h71;
    bus.req_data[63:32] = 32'h77;
    step();
    bus.req_valid = 4'h1;
    seen = 1'b0;
    for (int c = 0; c < 4 && !seen; c++) begin
      step();
      if (bus.cdb_valid && bus.cdb_tag == 8'h71) begin
        seen = 1'b1;
        chk("fair data1", 64'(bus.cdb_data), 64'h77);
      end
    end
    chk("fair req1 granted in 4", 64'(seen), 64'd1);
    drive(4'h0, 8'h00, 32'h0);
    for (int c = 0; c < 4; c++) step();
    chk("drain idle", 64'(bus.idle), 64'd1);
    // three queued results are discarded by a one-cycle reset; pushes during reset ignored
    drive(4'h7, 8'h80, 32'h800);
    step();
    chk("prereset busy", 64'(bus.idle), 64'd0);
    rst_n = 1'b0;
    drive(4'hF, 8'h90, 32'h900);
    step();
    chk("rst cdb_valid", 64'(bus.cdb_valid), 64'd0);
    chk("rst idle", 64'(bus.idle), 64'd1);
    chk("rst req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst cdb_tag", 64'(bus.cdb_tag), 64'd0);
    chk("rst cdb_data", 64'(bus.cdb_data), 64'd0);
    rst_n = 1'b1;
    drive(4'h0, 8'h00, 32'h0);
    stale = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      stale = stale | bus.cdb_valid;
    end
    chk("no stale bcast", 64'(stale), 64'd0);
    chk("post reset idle", 64'(bus.idle), 64'd1);
    chk("post reset ready", 64'(bus.req_ready), 64'hF);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
